// File: rtl/field_pkg.sv
// Shared constants and types for the MSM field-reduction datapath.
//
// Holds the default width, the base-field (p) and scalar-field (q) moduli
// with their Barrett constants mu = floor(2^(2W) / P), and the squares P^2
// used to flag out-of-range operands. Also defines the per-stage control
// record that travels alongside the operand through the reducer pipeline.
package field_pkg;

    localparam int FIELD_W     = 128;
    localparam int FIELD_TAG_W = 8;

    // Base field modulus p = 2^128 - 159.
    // Because p = 2^128 - c with a small c, mu = 2^128 + c exactly.
    localparam logic [127:0] P_BASE    = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF61;
    localparam logic [128:0] MU_BASE   = 129'h1_0000_0000_0000_0000_0000_0000_0000_009F;

    // Scalar field modulus q = 2^128 - 173, mu = 2^128 + 173.
    localparam logic [127:0] P_SCALAR  = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF53;
    localparam logic [128:0] MU_SCALAR = 129'h1_0000_0000_0000_0000_0000_0000_0000_00AD;

    // Squares of the default moduli; operands at or above these are outside
    // the range the reducer is designed for.
    localparam logic [255:0] P_BASE_SQ   = 256'(P_BASE) * 256'(P_BASE);
    localparam logic [255:0] P_SCALAR_SQ = 256'(P_SCALAR) * 256'(P_SCALAR);

    // Control bits carried by every pipeline stage. The tag rides in a
    // parallel register because its width is a per-instance parameter.
    typedef struct packed {
        logic valid;
        logic sel;
        logic err;
    } stage_ctl_t;

endpackage

// File: rtl/pipe_mult.sv
// Registered unsigned multiplier with a pipeline enable.
//
// p = ((a * b) >> SHIFT) truncated to PW bits, captured on clk when en=1.
// SHIFT lets the caller keep only the upper product bits; PW lets it keep
// only the low bits, so unused product bits never reach a register.
//
// Ports:
//   clk  in   1      rising-edge clock
//   en   in   1      load enable (held low to freeze the register)
//   a    in   AW     multiplicand, unsigned
//   b    in   BW     multiplier, unsigned
//   p    out  PW     registered (shifted, truncated) product
module pipe_mult #(
    parameter int AW    = 8,
    parameter int BW    = 8,
    parameter int SHIFT = 0,
    parameter int PW    = AW + BW - SHIFT
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] a,
    input  logic [BW-1:0] b,
    output logic [PW-1:0] p
);

    logic [PW-1:0] p_d;
    logic [PW-1:0] p_q;

    // Both operands are widened to the full product width first so the
    // multiply never loses its upper bits before the shift.
    always_comb begin
        p_d = PW'(({{BW{1'b0}}, a} * {{AW{1'b0}}, b}) >> SHIFT);
    end

    always_ff @(posedge clk) begin
        if (en) begin
            p_q <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: rtl/barrett_reduce_pipe.sv
// Fully pipelined dual-modulus Barrett reducer: out_r = in_a mod P_sel.
//
// Four register stages, one operand per cycle, fixed 4-cycle latency:
//   S1  q_est = (a * MU_sel) >> 2W, and err = (a >= P_sel^2)
//   S2  qp    = q_est * P_sel (only the low W+2 bits are kept)
//   S3  t     = a - qp in W+2 bits, 0 <= t < 3P
//   S4  conditional subtract of 2P or P, output register
// A single global stall (output valid but not accepted) freezes every stage.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high
//   in_valid   in   1      operand presented
//   in_ready   out  1      block can accept this cycle
//   in_a       in   2W     operand, unsigned
//   in_sel     in   1      0 -> P0, 1 -> P1
//   in_tag     in   TAG_W  sideband tag, returned unchanged
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts
//   out_r      out  W      residue, always < P_sel
//   out_tag    out  TAG_W  tag of this result
//   out_err    out  1      operand was >= P_sel^2
module barrett_reduce_pipe
    import field_pkg::*;
#(
    parameter int               WIDTH = FIELD_W,
    parameter logic [WIDTH-1:0] P0    = P_BASE,
    parameter logic [WIDTH:0]   MU0   = MU_BASE,
    parameter logic [WIDTH-1:0] P1    = P_SCALAR,
    parameter logic [WIDTH:0]   MU1   = MU_SCALAR,
    parameter int               TAG_W = FIELD_TAG_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] in_a,
    input  logic               in_sel,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_r,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_err
);

    // The residue before final correction is below 3P < 2^(W+2), so only the
    // low W+2 bits of a and q*P ever matter after S1.
    localparam int TW = WIDTH + 2;

    localparam logic [2*WIDTH-1:0] P0_SQ = (2*WIDTH)'(P0) * (2*WIDTH)'(P0);
    localparam logic [2*WIDTH-1:0] P1_SQ = (2*WIDTH)'(P1) * (2*WIDTH)'(P1);

    logic stall;
    logic en;

    stage_ctl_t s1_d, s1_q;
    stage_ctl_t s2_d, s2_q;
    stage_ctl_t s3_d, s3_q;

    logic [TAG_W-1:0] tag1_d, tag1_q;
    logic [TAG_W-1:0] tag2_d, tag2_q;
    logic [TAG_W-1:0] tag3_d, tag3_q;

    logic [TW-1:0]    a1_d, a1_q;
    logic [TW-1:0]    a2_d, a2_q;
    logic [TW-1:0]    t_d, t_q;

    logic [WIDTH:0]   mu_sel;
    logic [WIDTH:0]   q_est;
    logic [WIDTH-1:0] p_sel2;
    logic [TW-1:0]    qp;
    logic [TW-1:0]    p4;
    logic [TW-1:0]    p4_x2;

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] out_r_d, out_r_q;
    logic [TAG_W-1:0] out_tag_d, out_tag_q;
    logic             out_err_d, out_err_q;

    // Global stall: depends only on registered state and out_ready, never on in_*.
    assign stall    = out_valid_q && !out_ready;
    assign en       = !stall;
    assign in_ready = en;

    // S1 multiplier: keep only bits [3W:2W] of a*MU, i.e. the quotient estimate.
    pipe_mult #(
        .AW    (2*WIDTH),
        .BW    (WIDTH+1),
        .SHIFT (2*WIDTH),
        .PW    (WIDTH+1)
    ) u_mult_mu (
        .clk (clk),
        .en  (en),
        .a   (in_a),
        .b   (mu_sel),
        .p   (q_est)
    );

    // S2 multiplier: q_est * P, truncated to the W+2 bits the subtract needs.
    pipe_mult #(
        .AW    (WIDTH+1),
        .BW    (WIDTH),
        .SHIFT (0),
        .PW    (TW)
    ) u_mult_p (
        .clk (clk),
        .en  (en),
        .a   (q_est),
        .b   (p_sel2),
        .p   (qp)
    );

    always_comb begin
        // S1
        s1_d.valid = in_valid && in_ready;
        s1_d.sel   = in_sel;
        s1_d.err   = in_sel ? (in_a >= P1_SQ) : (in_a >= P0_SQ);
        tag1_d     = in_tag;
        a1_d       = in_a[TW-1:0];
        mu_sel     = in_sel ? MU1 : MU0;

        // S2
        s2_d       = s1_q;
        tag2_d     = tag1_q;
        a2_d       = a1_q;
        p_sel2     = s1_q.sel ? P1 : P0;

        // S3: modular (W+2)-bit subtract is exact because the true t < 3P.
        s3_d       = s2_q;
        tag3_d     = tag2_q;
        t_d        = a2_q - qp;

        // S4: at most two corrections are ever needed.
        p4         = TW'(s3_q.sel ? P1 : P0);
        p4_x2      = p4 << 1;
        if (t_q >= p4_x2) begin
            out_r_d = WIDTH'(t_q - p4_x2);
        end else if (t_q >= p4) begin
            out_r_d = WIDTH'(t_q - p4);
        end else begin
            out_r_d = WIDTH'(t_q);
        end
        out_valid_d = s3_q.valid;
        out_tag_d   = tag3_q;
        out_err_d   = s3_q.err;
    end

    // Control and output registers: cleared by reset, frozen by stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_tag_q   <= '0;
            out_err_q   <= 1'b0;
        end else if (en) begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            out_valid_q <= out_valid_d;
            out_r_q     <= out_r_d;
            out_tag_q   <= out_tag_d;
            out_err_q   <= out_err_d;
        end
    end

    // Datapath registers: contents are don't-care while the matching valid is 0.
    always_ff @(posedge clk) begin
        if (en) begin
            tag1_q <= tag1_d;
            tag2_q <= tag2_d;
            tag3_q <= tag3_d;
            a1_q   <= a1_d;
            a2_q   <= a2_d;
            t_q    <= t_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_r     = out_r_q;
    assign out_tag   = out_tag_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Scoreboard bench for barrett_reduce_pipe at W=8 with moduli 251 and 241.
// The driver pushes a mod P (plain % arithmetic) on each accepted operand;
// an independent monitor pops and compares whenever a result is transferred.
module tb_barrett_reduce_pipe;

    localparam int W  = 8;
    localparam int TW = 4;
    localparam int P0 = 251;
    localparam int P1 = 241;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [2*W-1:0] in_a;
    logic          in_sel;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_r;
    logic [TW-1:0] out_tag;
    logic          out_err;

    always #5 clk = ~clk;

    barrett_reduce_pipe #(
        .WIDTH (W),
        .P0    (8'd251),
        .MU0   (9'd261),
        .P1    (8'd241),
        .MU1   (9'd271),
        .TAG_W (TW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_sel    (in_sel),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    typedef struct {
        int a;
        bit sel;
        int tag;
        int r;
        bit err;
        int cyc;
        bit lat_chk;
    } exp_t;

    exp_t sb[$];

    int n_checks   = 0;
    int n_errors   = 0;
    int cyc        = 0;
    bit lat_mode   = 1'b0;
    int ready_mode = 0;
    int rcnt       = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int modp(input bit sel);
        return sel ? P1 : P0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // out_ready generator: 0 = always ready, 1 = pattern 1-0-0, 2 = random.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            rcnt++;
            if (ready_mode == 1)      out_ready = ((rcnt % 3) == 0);
            else if (ready_mode == 2) out_ready = 1'($urandom_range(1));
            else                      out_ready = 1'b1;
        end
    end

    // Present one operand and hold it until accepted; record the expectation.
    task automatic send(input int a, input bit sel, input int tag);
        exp_t e;
        int   waited = 0;
        bit   done   = 1'b0;
        int   p;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a[2*W-1:0];
        in_sel   = sel;
        in_tag   = tag[TW-1:0];
        #2;
        if (ready_mode == 0) check("accept_now", in_ready, 1);
        while (!done) begin
            if (in_ready) begin
                p         = modp(sel);
                e.a       = a;
                e.sel     = sel;
                e.tag     = tag & ((1 << TW) - 1);
                e.r       = a % p;
                e.err     = (a >= p * p);
                e.cyc     = cyc;
                e.lat_chk = lat_mode;
                sb.push_back(e);
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 100) begin
                    check("accept_timeout", waited, 0);
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                    #2;
                end
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_state();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_r", out_r, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_err", out_err, 0);
        check("rst_in_ready", in_ready, 1);
    endtask

    // Monitor: handshake, hold and scoreboard comparisons.
    initial begin
        exp_t         e;
        bit           held = 1'b0;
        logic [W-1:0]  h_r;
        logic [TW-1:0] h_tag;
        logic          h_err;
        forever begin
            @(negedge clk);
            #3;
            if (reset) begin
                held = 1'b0;
            end else begin
                check("in_ready_rule", in_ready, !(out_valid && !out_ready));
                if (held) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_r", out_r, h_r);
                    check("hold_tag", out_tag, h_tag);
                    check("hold_err", out_err, h_err);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_out", out_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        check("r", out_r, e.r);
                        check("tag", out_tag, e.tag);
                        check("err", out_err, e.err);
                        check("r_lt_p", (out_r < modp(e.sel)), 1);
                        if (e.lat_chk) check("latency", cyc - e.cyc, 4);
                    end
                end
                held  = out_valid && !out_ready;
                h_r   = out_r;
                h_tag = out_tag;
                h_err = out_err;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_a     = '0;
        in_sel   = 1'b0;
        in_tag   = '0;
        repeat (3) @(negedge clk);
        check_reset_state();
        reset = 1'b0;

        // 1. zero operand, tag passes through, exact latency
        lat_mode = 1'b1;
        send(0, 1'b0, 3);
        idle();
        drain(20);

        // 2. same operand, both moduli, back-to-back
        send(62500, 1'b0, 1);
        send(62500, 1'b1, 2);
        idle();
        drain(20);

        // 3. out-of-contract and boundary operands
        send(65535, 1'b0, 5);
        send(250, 1'b1, 6);
        send(63001, 1'b0, 7);
        send(63000, 1'b0, 8);
        send(58081, 1'b1, 9);
        send(58080, 1'b1, 10);
        send(251, 1'b0, 11);
        send(502, 1'b0, 12);
        send(241, 1'b1, 13);
        send(482, 1'b1, 14);
        for (int i = 0; i < 8; i++) begin
            send(int'($urandom_range(65535)), 1'($urandom_range(1)), int'($urandom_range(15)));
        end
        idle();
        drain(40);

        // 4. ten in-range operands with out_ready pattern 1-0-0
        lat_mode   = 1'b0;
        ready_mode = 1;
        for (int i = 0; i < 10; i++) begin
            bit s;
            s = 1'($urandom_range(1));
            send(int'($urandom_range(modp(s) * modp(s) - 1)), s, i);
        end
        idle();
        drain(200);

        // random backpressure with random full-range operands
        ready_mode = 2;
        for (int i = 0; i < 50; i++) begin
            send(int'($urandom_range(65535)), 1'($urandom_range(1)), int'($urandom_range(15)));
        end
        idle();
        drain(400);

        // 5. reset while three operands are in flight
        ready_mode = 0;
        lat_mode   = 1'b1;
        send(1000, 1'b0, 1);
        send(2000, 1'b1, 2);
        send(3000, 1'b0, 3);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        check_reset_state();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #3;
            check("no_out_after_reset", out_valid, 0);
        end
        send(500, 1'b0, 4);
        idle();
        drain(20);

        // 6. strided sweep of [0, P^2) for both moduli at full rate
        for (int a = 0; a < P0 * P0; a += 3) begin
            send(a, 1'b0, a & 15);
            if (a < P1 * P1) send(a, 1'b1, (a >> 4) & 15);
        end
        send(P0 * P0 - 1, 1'b0, 1);
        send(P1 * P1 - 1, 1'b1, 2);
        idle();
        drain(50);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
